// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that time-shares one sequential start/done multiplier core
// among N_REQ requesters and returns tagged products on a single response channel.
module booth_mul_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_mc,
    input  logic [N_REQ*WIDTH-1:0] req_mp,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]     rsp_prod,
    output logic                   rsp_err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_mc,
    output logic [WIDTH-1:0]       mul_mp,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_prod
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t               state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic [WIDTH-1:0]     mc_q, mc_d;
    logic [WIDTH-1:0]     mp_q, mp_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 err_q, err_d;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W-1:0]      cand;
    logic [N_REQ-1:0]     ready_d;

    // Scan starting one past the last served requester so each client gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(last_grant_q) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        last_grant_d = last_grant_q;
        mc_d         = mc_q;
        mp_d         = mp_q;
        id_d         = id_q;
        prod_d       = prod_q;
        err_d        = err_q;
        ready_d      = '0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    ready_d[grant_idx] = 1'b1;
                    mc_d    = req_mc[int'(grant_idx)*WIDTH +: WIDTH];
                    mp_d    = req_mp[int'(grant_idx)*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done wins over timeout, so a pulse in the last allowed cycle still counts.
                if (mul_done) begin
                    prod_d  = mul_prod;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    last_grant_d = id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
            mc_q         <= '0;
            mp_q         <= '0;
            id_q         <= '0;
            prod_q       <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            last_grant_q <= last_grant_d;
            mc_q         <= mc_d;
            mp_q         <= mp_d;
            id_q         <= id_d;
            prod_q       <= prod_d;
            err_q        <= err_d;
        end
    end

    // The handshake is combinational, so mask it while reset holds the block idle.
    assign req_ready = rst ? '0 : ready_d;
    assign rsp_valid = (state_q == RESP);
    assign mul_start = (state_q == ISSUE);
    assign mul_mc    = mc_q;
    assign mul_mp    = mp_q;
    assign rsp_id    = id_q;
    assign rsp_prod  = prod_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed self-checking bench for booth_mul_arbiter with a behavioural
// fixed-latency multiplier core standing in for the real one.
module tb_booth_mul_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 15;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_mc;
    logic [N_REQ*WIDTH-1:0] req_mp;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [1:0]             rsp_id;
    logic [7:0]             rsp_prod;
    logic                   rsp_err;
    logic                   mul_start;
    logic [3:0]             mul_mc;
    logic [3:0]             mul_mp;
    logic                   mul_done = 1'b0;
    logic [7:0]             mul_prod = 8'h00;

    int   passed = 0;
    int   total  = 0;
    int   failed = 0;
    int   cyc    = 0;

    int   core_lat   = 1;
    logic core_en    = 1'b1;
    logic force_done = 1'b0;
    logic [7:0] force_prod = 8'h00;
    logic core_busy = 1'b0;
    int   core_cnt  = 0;

    booth_mul_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mc(req_mc), .req_mp(req_mp),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp),
        .mul_done(mul_done), .mul_prod(mul_prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done arrives core_lat cycles after the start cycle; force_done injects a stray pulse.
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (force_done) begin
            mul_done <= 1'b1;
            mul_prod <= force_prod;
        end else if (core_busy) begin
            if (core_cnt == 1) begin
                mul_done  <= 1'b1;
                core_busy <= 1'b0;
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
        if (mul_start && core_en) begin
            mul_prod <= {{4{mul_mc[3]}}, mul_mc} * {{4{mul_mp[3]}}, mul_mp};
            if (core_lat <= 1) begin
                mul_done <= 1'b1;
            end else begin
                core_busy <= 1'b1;
                core_cnt  <= core_lat - 1;
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [3:0] mc, input logic [3:0] mp);
        req_mc[idx*WIDTH +: WIDTH] = mc;
        req_mp[idx*WIDTH +: WIDTH] = mp;
        req_valid = '0;
        req_valid[idx] = 1'b1;
    endtask

    task automatic waitResp(input int maxc, output int n);
        n = 0;
        while (!rsp_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int gcnt;
        int gid[6];
        int gcyc[6];
        logic saw;

        rst = 1'b1;
        req_valid = '0;
        req_mc = '0;
        req_mp = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {req_ready, rsp_valid, mul_start, mul_mc, mul_mp, rsp_id, rsp_prod, rsp_err}, 32'h0);
        rst = 1'b0;

        // Single operation: 3 * -2 with latency 5.
        @(negedge clk);
        core_lat = 5;
        applyStimulus(0, 4'h3, 4'hE);
        #1 checkOutput("single_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        checkOutput("single_start", mul_start, 1);
        checkOutput("single_operands", {mul_mc, mul_mp}, 8'h3E);
        waitResp(30, n);
        checkOutput("single_latency", n, 6);
        checkOutput("single_rsp", {rsp_err, rsp_id, rsp_prod}, {1'b0, 2'd0, 8'hFA});
        @(negedge clk);
        checkOutput("single_rsp_done", rsp_valid, 0);

        // Corner operands through requesters 1 and 3.
        core_lat = 2;
        applyStimulus(1, 4'h8, 4'h8);
        #1 checkOutput("corner88_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        waitResp(30, n);
        checkOutput("corner88_latency", n, 3);
        checkOutput("corner88_rsp", {rsp_err, rsp_id, rsp_prod}, {1'b0, 2'd1, 8'h40});
        @(negedge clk);
        applyStimulus(3, 4'h7, 4'h8);
        #1 checkOutput("corner78_ready", req_ready, 4'b1000);
        @(negedge clk);
        req_valid = '0;
        waitResp(30, n);
        checkOutput("corner78_rsp", {rsp_err, rsp_id, rsp_prod}, {1'b0, 2'd3, 8'hC8});
        @(negedge clk);

        // Timeout: core never answers; a late done in RESP must not change the response.
        core_en = 1'b0;
        rsp_ready = 1'b0;
        applyStimulus(0, 4'h5, 4'h5);
        #1 checkOutput("timeout_ready", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        waitResp(40, n);
        checkOutput("timeout_latency", n, 16);
        checkOutput("timeout_rsp", {rsp_err, rsp_prod}, 9'h100);
        force_prod = 8'h55;
        force_done = 1'b1;
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        checkOutput("timeout_late_done", {rsp_valid, rsp_err, rsp_prod}, 10'h300);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("timeout_rsp_done", rsp_valid, 0);
        core_en = 1'b1;

        // Backpressure: response held for 10 cycles with other requests pending.
        rsp_ready = 1'b0;
        core_lat = 1;
        applyStimulus(2, 4'h2, 4'h3);
        #1 checkOutput("bp_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = 4'b0011;
        waitResp(20, n);
        checkOutput("bp_latency", n, 2);
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold", {rsp_valid, rsp_id, rsp_prod, req_ready}, {1'b1, 2'd2, 8'h06, 4'b0000});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_next_grant", {rsp_valid, req_ready}, {1'b0, 4'b0001});
        req_valid = '0;
        #1;

        // Reset during WAIT, followed by a stray done from the core model.
        core_lat = 8;
        applyStimulus(1, 4'h6, 4'h6);
        #1 checkOutput("rstwait_ready", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 checkOutput("rstwait_outputs",
                       {req_ready, rsp_valid, mul_start, mul_mc, mul_mp, rsp_id, rsp_prod, rsp_err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid || mul_start) saw = 1'b1;
        end
        checkOutput("rstwait_no_rsp", saw, 0);
        core_lat = 3;
        applyStimulus(2, 4'h5, 4'hD);
        #1 checkOutput("rstwait_req2_ready", req_ready, 4'b0100);
        @(negedge clk);
        req_valid = '0;
        waitResp(30, n);
        checkOutput("rstwait_req2_latency", n, 4);
        checkOutput("rstwait_req2_rsp", {rsp_err, rsp_id, rsp_prod}, {1'b0, 2'd2, 8'hF1});
        @(negedge clk);

        // Contention: all four requesters held from reset, latency 1.
        rst = 1'b1;
        @(negedge clk);
        req_mc = 16'h4321;
        req_mp = 16'h1111;
        core_lat = 1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        rst = 1'b0;
        #1;
        gcnt = 0;
        for (int c = 0; c < 40 && gcnt < 6; c++) begin
            if (req_ready != '0) begin
                checkOutput("cont_onehot", {31'h0, $onehot(req_ready)}, 1);
                gid[gcnt] = 0;
                for (int b = 0; b < N_REQ; b++) if (req_ready[b]) gid[gcnt] = b;
                gcyc[gcnt] = cyc;
                gcnt++;
            end
            @(negedge clk);
        end
        checkOutput("cont_grant_count", gcnt, 6);
        for (int i = 0; i < gcnt; i++) checkOutput("cont_order", gid[i], i % N_REQ);
        for (int i = 1; i < gcnt; i++) checkOutput("cont_spacing", gcyc[i] - gcyc[i-1], 4);
        req_valid = '0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
